// File: rtl/imm_pkg.sv
// Shared constants for the RV32I immediate encoder: format codes, opcodes,
// funct3 values, the nop word, the S1 stage record and the legality check.
package imm_pkg;

  localparam logic [3:0] FMT_LW  = 4'd0;
  localparam logic [3:0] FMT_SW  = 4'd1;
  localparam logic [3:0] FMT_BEQ = 4'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Only imm[12:0] is needed downstream once the range check has been taken.
  typedef struct packed {
    logic [3:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        err;
  } s1_t;

  function automatic logic req_illegal(input logic [3:0] fmt, input logic [31:0] imm);
    logic signed [31:0] simm;
    logic               bad;
    simm = $signed(imm);
    case (fmt)
      FMT_LW, FMT_SW: bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      FMT_BEQ:        bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational RV32I field packing of a registered S1 record; illegal
// requests collapse to the canonical nop.
module imm_enc_pack
  import imm_pkg::*;
(
  input  s1_t         s1,
  output logic [31:0] instr
);

  always_comb begin
    instr = NOP_INSTR;
    if (!s1.err) begin
      case (s1.fmt)
        FMT_LW:  instr = {s1.imm[11:0], s1.rs1, F3_LW, s1.rd, OP_LOAD};
        FMT_SW:  instr = {s1.imm[11:5], s1.rs2, s1.rs1, F3_SW, s1.imm[4:0], OP_STORE};
        FMT_BEQ: instr = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, F3_BEQ,
                          s1.imm[4:1], s1.imm[11], OP_BRANCH};
        default: instr = NOP_INSTR;
      endcase
    end
  end

endmodule

// File: rtl/imm_enc.sv
// Two-stage RV32I load/store/branch encoder with valid/ready on both sides
// and a wrapping count of completed output transfers.
module imm_enc
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a pending word is held stable.
  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic [31:0]      s2_instr;
  logic             s2_err;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pack_instr;
  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  logic             emit;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = !rst && s1_adv;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign out_valid = s2_valid && !rst;
  assign out_instr = rst ? 32'h0 : s2_instr;
  assign out_err   = s2_err && !rst;
  assign enc_cnt   = rst ? '0 : cnt_q;

  imm_enc_pack u_pack (
    .s1    (s1_q),
    .instr (pack_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_instr <= 32'h0;
      s2_err   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_q <= {in_fmt, in_rd, in_rs1, in_rs2, in_imm[12:0],
                   req_illegal(in_fmt, in_imm)};
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= pack_instr;
          s2_err   <= s1_q.err;
        end
      end
      if (emit) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: directed vector table, backpressure and mid-flight reset
// sequences, and a randomized stream scored against an arithmetic model.
module tb_imm_enc;
  import imm_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_fmt;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_cnt;

  imm_enc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_cnt   (enc_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the instruction-format rules, using plain arithmetic.
  function automatic logic [32:0] ref_enc(input logic [3:0] fmt, input int rd, input int rs1,
                                          input int rs2, input int imm);
    logic [31:0] w;
    logic [31:0] u;
    logic        bad;
    w = 32'h13;
    u = 32'(imm);
    case (fmt)
      4'd0, 4'd1: bad = (imm < -2048) || (imm > 2047);
      4'd2:       bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
      default:    bad = 1'b1;
    endcase
    if (!bad && fmt == 4'd0) begin
      u = u & 32'hfff;
      w = u * 32'h10_0000 + rs1 * 32'h8000 + 2 * 32'h1000 + rd * 32'h80 + 3;
    end else if (!bad && fmt == 4'd1) begin
      u = u & 32'hfff;
      w = (u / 32) * 32'h200_0000 + rs2 * 32'h10_0000 + rs1 * 32'h8000 + 2 * 32'h1000
          + (u % 32) * 32'h80 + 35;
    end else if (!bad && fmt == 4'd2) begin
      u = u & 32'h1fff;
      w = (u / 4096) * 32'h8000_0000 + ((u / 32) % 64) * 32'h200_0000 + rs2 * 32'h10_0000
          + rs1 * 32'h8000 + ((u / 2) % 16) * 32'h100 + ((u / 2048) % 2) * 32'h80 + 99;
    end
    return {bad, w};
  endfunction

  // Independent immediate decoder used for the round-trip check.
  function automatic int imm_gen(input logic [31:0] ins);
    logic [31:0] v;
    case (ins[6:0])
      7'b0000011: v = {{20{ins[31]}}, ins[31:20]};
      7'b0100011: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default:    v = 32'h0;
    endcase
    return int'(v);
  endfunction

  // Scoreboard: accepted requests are modelled and queued; outputs pop and compare.
  logic [32:0]      exp_q[$];
  int               imm_q[$];
  logic [CNT_W-1:0] sb_cnt = '0;
  logic             prev_stall = 1'b0;
  logic [32:0]      held;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_err, out_instr}), 64'(held));
      end
      prev_stall = out_valid && !out_ready;
      held = {out_err, out_instr};
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_enc(in_fmt, int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm)));
        imm_q.push_back(int'(in_imm));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 64'({out_err, out_instr}), 64'h1_dead_beef);
        end else begin
          logic [32:0] e;
          int          im;
          e  = exp_q.pop_front();
          im = imm_q.pop_front();
          check("sb_result", 64'({out_err, out_instr}), 64'(e));
          if (!e[32]) check("sb_imm_roundtrip", 64'(imm_gen(out_instr)), 64'(im));
          sb_cnt = sb_cnt + 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] f, input int rd, input int rs1, input int rs2, input int imm);
    in_fmt = f;
    in_rd  = 5'(rd);
    in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2);
    in_imm = 32'(imm);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    exp_q.delete();
    imm_q.delete();
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_enc_cnt", 64'(enc_cnt), 64'd0);
    tick();
    tick();
    rst    = 1'b0;
    sb_cnt = '0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && guard < 40) begin
      tick();
      guard++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  fmt;
    int          rd;
    int          rs1;
    int          rs2;
    int          imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];
  int   bp_imm[9];
  logic [3:0] bp_fmt[9];

  initial begin
    vecs[0] = '{4'd0, 30, 1, 0, 8,     32'h0080af03, 1'b0};
    vecs[1] = '{4'd0, 30, 1, 0, -8,    32'hff80af03, 1'b0};
    vecs[2] = '{4'd1, 0,  1, 2, -12,   32'hfe20aa23, 1'b0};
    vecs[3] = '{4'd1, 0,  1, 2, 4,     32'h0020a223, 1'b0};
    vecs[4] = '{4'd2, 0,  1, 2, 8,     32'h00208463, 1'b0};
    vecs[5] = '{4'd2, 0,  5, 11, -14,  32'hfeb289e3, 1'b0};
    vecs[6] = '{4'd0, 3,  4, 0, 2048,  32'h00000013, 1'b1};
    vecs[7] = '{4'd2, 0,  1, 2, 3,     32'h00000013, 1'b1};
    vecs[8] = '{4'd2, 0,  1, 2, 4096,  32'h00000013, 1'b1};
    vecs[9] = '{4'd7, 1,  1, 1, 0,     32'h00000013, 1'b1};

    out_ready = 1'b1;
    drive(4'd0, 0, 0, 0, 0);
    do_reset();

    // Directed table: accept, confirm empty output next cycle, result on the second.
    foreach (vecs[i]) begin
      drive(vecs[i].fmt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      in_valid = 1'b1;
      #1;
      check("vec_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("vec_lat1_idle", 64'(out_valid), 64'd0);
      tick();
      check("vec_lat2_valid", 64'(out_valid), 64'd1);
      check("vec_instr", 64'(out_instr), 64'(vecs[i].exp_instr));
      check("vec_err", 64'(out_err), 64'(vecs[i].exp_err));
      tick();
    end
    drain();

    // Backpressure: 9 back-to-back requests, out_ready low on stream cycles 3..6.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bp_fmt[i] = 4'($urandom_range(0, 2));
      bp_imm[i] = (bp_fmt[i] == 4'd2) ? int'($urandom_range(0, 4095)) * 2 - 4096
                                      : int'($urandom_range(0, 4095)) - 2048;
    end
    begin
      int   idx, k, low_cycles, first_low;
      logic acc;
      idx = 0; k = 0; low_cycles = 0; first_low = -1;
      while (idx < 9 && k < 60) begin
        out_ready = !(k >= 3 && k <= 6);
        drive(bp_fmt[idx], int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), bp_imm[idx]);
        in_valid = 1'b1;
        #1;
        acc = in_ready;
        if (!in_ready) begin
          low_cycles++;
          if (first_low < 0) first_low = k;
        end
        @(posedge clk);
        #1;
        if (acc) idx++;
        k++;
      end
      check("bp_all_accepted", 64'(idx), 64'd9);
      check("bp_first_stall_cycle", 64'(first_low), 64'd3);
      check("bp_stall_cycles", 64'(low_cycles), 64'd4);
    end
    drain();
    check("bp_enc_cnt", 64'(enc_cnt), 64'd9);

    // Reset with both stages full: nothing may leave, counter stays zero.
    do_reset();
    out_ready = 1'b0;
    drive(4'd0, 1, 2, 3, 100);
    in_valid = 1'b1;
    tick();
    drive(4'd1, 4, 5, 6, -100);
    tick();
    in_valid = 1'b0;
    tick();
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    do_reset();
    check("mid_rst_enc_cnt", 64'(enc_cnt), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    check("mid_rst_no_ghost", 64'(out_valid), 64'd0);
    check("mid_rst_cnt_after", 64'(enc_cnt), 64'd0);

    // Randomized stream with random backpressure; counter wraps several times.
    begin
      logic acc;
      int   r;
      for (int c = 0; c < 500; c++) begin
        if (!in_valid && $urandom_range(0, 3) != 0) begin
          r = int'($urandom_range(0, 19));
          drive((r < 2) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 12000)) - 6000);
          if (r == 19) in_imm = $urandom;
          in_valid = 1'b1;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
      end
    end
    drain();
    check("rand_enc_cnt", 64'(enc_cnt), 64'(sb_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
